// File: rtl/display_bcd_formatter.sv
// display_bcd_formatter: binary-to-BCD display formatter with valid/ready
// handshakes. One double-dabble step per clock, followed by one formatting
// cycle that registers digit codes, blanking, sign, decimal point and overflow.
//
// state | meaning
// IDLE  | in_ready high, waiting for an input handshake
// CONV  | DATA_W shift-add-3 steps, one per clock
// FMT   | builds and registers the display outputs
// DONE  | result held with out_valid high until out_ready
module display_bcd_formatter #(
  parameter int         DATA_W      = 16,
  parameter int         DIGITS      = 6,
  parameter int         FRAC_DIGITS = 2,
  parameter int         SIGNED      = 1,
  parameter logic [3:0] SIGN_CODE   = 4'hA
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   data_out,
  output logic [DIGITS-1:0]     dat_en,
  output logic [DIGITS-1:0]     dot_en,
  output logic                  neg,
  output logic                  ovf
);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DATA_W);
  // A negative value gives up its leftmost digit to the minus sign.
  localparam logic [63:0] LIMIT_POS = pow10(DIGITS) - 64'd1;
  localparam logic [63:0] LIMIT_NEG = pow10(DIGITS - 1) - 64'd1;
  localparam logic [DIGITS-1:0] DOT_MASK =
    (FRAC_DIGITS > 0) ? (DIGITS'(1) << FRAC_DIGITS) : '0;

  typedef enum logic [1:0] {IDLE, CONV, FMT, DONE} state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [BW-1:0]       bcd_q;
  logic [DATA_W-1:0]   mag_q;
  logic                in_neg_q;
  logic                in_ovf_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [BW-1:0]       data_out_q;
  logic [DIGITS-1:0]   dat_en_q;
  logic [DIGITS-1:0]   dot_en_q;
  logic                neg_q;
  logic                ovf_q;

  logic                neg_d;
  logic [DATA_W-1:0]   mag_d;
  logic                ovf_d;
  logic [BW-1:0]       bcd_adj;
  logic [BW-1:0]       bcd_d;
  logic [BW-1:0]       code_d;
  logic [DIGITS-1:0]   en_d;
  int                  lead;

  // Sign, magnitude and overflow of the value presented at the input.
  // The most negative value maps to magnitude 2^(DATA_W-1) as unsigned bits.
  always_comb begin
    neg_d = (SIGNED != 0) && data_in[DATA_W-1];
    mag_d = neg_d ? (~data_in + DATA_W'(1)) : data_in;
    ovf_d = neg_d ? (64'(mag_d) > LIMIT_NEG) : (64'(mag_d) > LIMIT_POS);
  end

  // One double-dabble step: add 3 to every nibble >= 5, then shift in the next bit.
  // Bits that fall off the top only matter when the value overflowed anyway.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_d = {bcd_adj[BW-2:0], mag_q[DATA_W-1]};
  end

  // Digit codes and enables with leading-zero blanking and a floating sign.
  always_comb begin
    code_d = '0;
    en_d   = '0;
    lead   = 0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) lead = i;
    end
    if (lead < FRAC_DIGITS) lead = FRAC_DIGITS;
    if (in_ovf_q) begin
      for (int i = 0; i < DIGITS; i++) begin
        code_d[4*i +: 4] = 4'd9;
        en_d[i]          = 1'b1;
      end
      if (in_neg_q) code_d[BW-1 -: 4] = SIGN_CODE;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (i <= lead) begin
          code_d[4*i +: 4] = bcd_q[4*i +: 4];
          en_d[i]          = 1'b1;
        end else if (in_neg_q && (i == lead + 1)) begin
          code_d[4*i +: 4] = SIGN_CODE;
          en_d[i]          = 1'b1;
        end
      end
    end
  end

  // Control FSM with all handshake and display outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bcd_q       <= '0;
      mag_q       <= '0;
      in_neg_q    <= 1'b0;
      in_ovf_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      dat_en_q    <= '0;
      dot_en_q    <= '0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            mag_q      <= mag_d;
            in_neg_q   <= neg_d;
            in_ovf_q   <= ovf_d;
            bcd_q      <= '0;
            cnt_q      <= CW'(DATA_W - 1);
            in_ready_q <= 1'b0;
            state_q    <= CONV;
          end
        end
        CONV: begin
          bcd_q <= bcd_d;
          mag_q <= mag_q << 1;
          if (cnt_q == '0) state_q <= FMT;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        FMT: begin
          data_out_q  <= code_d;
          dat_en_q    <= en_d;
          dot_en_q    <= DOT_MASK;
          neg_q       <= in_neg_q;
          ovf_q       <= in_ovf_q;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign dat_en    = dat_en_q;
  assign dot_en    = dot_en_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_display_bcd_formatter.sv
// Directed bench for display_bcd_formatter: a default instance (6 digits,
// 2 fractional) and a 4-digit integer instance for overflow cases.
module tb_display_bcd_formatter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] data_in;
  logic        out_ready;
  logic        sel;

  logic        a_in_ready, a_out_valid, a_neg, a_ovf;
  logic [23:0] a_data;
  logic [5:0]  a_en, a_dot;
  logic        b_in_ready, b_out_valid, b_neg, b_ovf;
  logic [15:0] b_data;
  logic [3:0]  b_en, b_dot;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  display_bcd_formatter dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && !sel), .in_ready(a_in_ready),
    .data_in(data_in), .out_valid(a_out_valid), .out_ready(out_ready),
    .data_out(a_data), .dat_en(a_en), .dot_en(a_dot), .neg(a_neg), .ovf(a_ovf)
  );

  display_bcd_formatter #(.DATA_W(16), .DIGITS(4), .FRAC_DIGITS(0), .SIGNED(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel), .in_ready(b_in_ready),
    .data_in(data_in), .out_valid(b_out_valid), .out_ready(out_ready),
    .data_out(b_data), .dat_en(b_en), .dot_en(b_dot), .neg(b_neg), .ovf(b_ovf)
  );

  wire        m_in_ready  = sel ? b_in_ready  : a_in_ready;
  wire        m_out_valid = sel ? b_out_valid : a_out_valid;
  wire [23:0] m_data      = sel ? {8'h00, b_data} : a_data;
  wire [5:0]  m_en        = sel ? {2'b00, b_en}   : a_en;
  wire [5:0]  m_dot       = sel ? {2'b00, b_dot}  : a_dot;
  wire        m_neg       = sel ? b_neg : a_neg;
  wire        m_ovf       = sel ? b_ovf : a_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction with out_ready high; checks latency, outputs and return to IDLE.
  task automatic run(input logic s, input string tag, input logic [15:0] val,
                     input logic [23:0] exp_data, input logic [5:0] exp_en,
                     input logic [5:0] exp_dot, input logic exp_neg, input logic exp_ovf);
    int lat;
    sel = s;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = val;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "/busy"}, m_in_ready, 0);
    lat = 0;
    while (!m_out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "/latency"}, lat, 17);
    check({tag, "/data"}, m_data, exp_data);
    check({tag, "/dat_en"}, m_en, exp_en);
    check({tag, "/dot_en"}, m_dot, exp_dot);
    check({tag, "/neg"}, m_neg, exp_neg);
    check({tag, "/ovf"}, m_ovf, exp_ovf);
    @(negedge clk);
    check({tag, "/valid_drop"}, m_out_valid, 0);
    check({tag, "/ready_back"}, m_in_ready, 1);
  endtask

  initial begin
    int lat;
    int bad;
    rst_n = 1'b0; in_valid = 1'b0; data_in = '0; out_ready = 1'b1; sel = 1'b0;
    repeat (3) @(negedge clk);
    check("rst/in_ready", a_in_ready, 1);
    check("rst/out_valid", a_out_valid, 0);
    check("rst/data", a_data, 0);
    check("rst/dat_en", a_en, 0);
    check("rst/dot_en", a_dot, 0);
    check("rst/neg_ovf", {a_neg, a_ovf}, 0);
    rst_n = 1'b1;

    run(0, "pos1234", 16'd1234, 24'h001234, 6'b001111, 6'b000100, 0, 0);
    run(0, "neg1234", 16'hFB2E, 24'h0A1234, 6'b011111, 6'b000100, 1, 0);
    run(0, "neg1",    16'hFFFF, 24'h00A001, 6'b001111, 6'b000100, 1, 0);
    run(0, "zero",    16'h0000, 24'h000000, 6'b000111, 6'b000100, 0, 0);
    run(0, "max",     16'h7FFF, 24'h032767, 6'b011111, 6'b000100, 0, 0);
    run(0, "min",     16'h8000, 24'hA32768, 6'b111111, 6'b000100, 1, 0);
    run(1, "b_ovf",   16'd12345, 24'h009999, 6'b001111, 6'b000000, 0, 1);
    run(1, "b_novf",  16'hFC18, 24'h00A999, 6'b001111, 6'b000000, 1, 1);
    run(1, "b_9999",  16'd9999, 24'h009999, 6'b001111, 6'b000000, 0, 0);
    run(1, "b_m999",  16'hFC19, 24'h00A999, 6'b001111, 6'b000000, 1, 0);
    run(1, "b_5",     16'd5,    24'h000005, 6'b000001, 6'b000000, 0, 0);

    // Backpressure: hold out_ready low for 20 cycles and try a second input.
    sel = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; data_in = 16'd1234;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!a_out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("bp/latency", lat, 17);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin in_valid = 1'b1; data_in = 16'd7777; end
      if (i == 6) in_valid = 1'b0;
      if (!a_out_valid || a_in_ready || a_data !== 24'h001234 || a_en !== 6'b001111) bad++;
      @(negedge clk);
    end
    check("bp/held_cycles_bad", bad, 0);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp/valid_drop", a_out_valid, 0);
    check("bp/ready_back", a_in_ready, 1);
    check("bp/data_kept", a_data, 24'h001234);
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (a_out_valid) bad++;
    end
    check("bp/no_second_result", bad, 0);

    // Reset during CONV cycle 8 discards the conversion.
    @(negedge clk);
    in_valid = 1'b1; data_in = 16'd1234;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst/in_ready", a_in_ready, 1);
    check("mid_rst/out_valid", a_out_valid, 0);
    check("mid_rst/data", a_data, 0);
    check("mid_rst/en", {a_en, a_dot}, 0);
    check("mid_rst/neg_ovf", {a_neg, a_ovf}, 0);
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (a_out_valid) bad++;
    end
    check("mid_rst/no_result", bad, 0);
    run(0, "after_rst42", 16'd42, 24'h000042, 6'b000111, 6'b000100, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
